// File: rtl/uart_rx_buffered_if.sv
// Receive-side stream bundle of uart_rx_buffered: head word of the receive
// FIFO with its status flags, the valid/ready drain handshake, the FIFO
// occupancy and the one-cycle event pulses.
interface uart_rx_buffered_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LEVEL_W    = 4
);
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_parity_err;
  logic                  rx_frame_err;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [LEVEL_W-1:0]    rx_level;
  logic                  rx_overrun;
  logic                  rx_break;

  // Receiver side: produces words and events, consumes rx_ready.
  modport master (
    output rx_data, rx_parity_err, rx_frame_err, rx_valid,
    input  rx_ready,
    output rx_level, rx_overrun, rx_break
  );

  // Consumer side.
  modport slave (
    input  rx_data, rx_parity_err, rx_frame_err, rx_valid,
    output rx_ready,
    input  rx_level, rx_overrun, rx_break
  );
endinterface

// File: rtl/uart_rx_buffered.sv
// Buffered UART receiver: 2-flop input synchroniser, oversampled 2-of-3
// majority bit decisions, configurable data/parity/stop format, break
// detection and a show-ahead receive FIFO drained over a valid/ready port.
module uart_rx_buffered #(
  parameter int    CLK_FREQ   = 50_000_000,
  parameter int    BAUD_RATE  = 115200,
  parameter int    OVERSAMPLE = 16,
  parameter int    DATA_WIDTH = 8,
  parameter string PARITY     = "NONE",
  parameter int    STOP_BITS  = 1,
  parameter int    FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               arstn,
  input  logic               RXD,
  uart_rx_buffered_if.master rx_if
);

  localparam int TICK_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SMP_W    = $clog2(OVERSAMPLE);
  localparam int BIT_W    = 4;
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int LEVEL_W  = $clog2(FIFO_DEPTH + 1);
  localparam int WORD_W   = DATA_WIDTH + 2;
  localparam bit HAS_PAR  = (PARITY != "NONE");
  localparam bit PAR_ODD  = (PARITY == "ODD");

  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(TICK_DIV - 1);
  localparam logic [SMP_W-1:0]   SMP_V0     = SMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SMP_W-1:0]   SMP_V1     = SMP_W'(OVERSAMPLE / 2);
  localparam logic [SMP_W-1:0]   SMP_DEC    = SMP_W'(OVERSAMPLE / 2 + 1);
  localparam logic [SMP_W-1:0]   SMP_LAST   = SMP_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]   DATA_LAST  = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]   STOP_LAST  = BIT_W'(STOP_BITS - 1);
  localparam logic [LEVEL_W-1:0] LEVEL_FULL = LEVEL_W'(FIFO_DEPTH);

  if (TICK_DIV < 1) begin : g_bad_div
    $error("uart_rx_buffered: CLK_FREQ too low for BAUD_RATE*OVERSAMPLE");
  end
  if ((OVERSAMPLE < 8) || (OVERSAMPLE % 2 != 0)) begin : g_bad_os
    $error("uart_rx_buffered: OVERSAMPLE must be even and >= 8");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_rx_buffered: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRKW
  } state_t;

  state_t                  state_q, state_d;
  logic                    sync1_q, sync2_q, prev_q;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [SMP_W-1:0]        smp_q, smp_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic                    v0_q, v0_d, v1_q, v1_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    perr_q, perr_d, ferr_q, ferr_d, zero_q, zero_d;
  logic                    push_q, push_d, brk_q, brk_d;
  logic [WORD_W-1:0]       word_q, word_d;

  logic [WORD_W-1:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LEVEL_W-1:0]      level_q, level_d;
  logic                    ovr_q, ovr_d;

  logic tick, start_edge, maj, at_v0, at_v1, at_dec, at_wrap;
  logic stop_ferr, stop_zero, pop, full, wr;
  logic [WORD_W-1:0] head;

  assign tick       = (state_q != S_IDLE) && (state_q != S_BRKW) && (div_q == DIV_LAST);
  assign start_edge = (state_q == S_IDLE) && prev_q && !sync2_q;
  assign at_v0      = tick && (smp_q == SMP_V0);
  assign at_v1      = tick && (smp_q == SMP_V1);
  assign at_dec     = tick && (smp_q == SMP_DEC);
  assign at_wrap    = tick && (smp_q == SMP_LAST);
  assign maj        = (v0_q & v1_q) | (v0_q & sync2_q) | (v1_q & sync2_q);
  assign stop_ferr  = ferr_q | ~maj;
  assign stop_zero  = zero_q & ~maj;

  // Bring RXD into the clock domain and keep the previous value for edge detect.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= RXD;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Frame FSM next state plus the tick/sample/bit counters and bit decisions.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    smp_d   = smp_q;
    bit_d   = bit_q;
    v0_d    = v0_q;
    v1_d    = v1_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    zero_d  = zero_q;
    push_d  = 1'b0;
    brk_d   = 1'b0;
    word_d  = word_q;

    if ((state_q == S_IDLE) || (state_q == S_BRKW)) begin
      div_d = '0;
      smp_d = '0;
    end else if (tick) begin
      div_d = '0;
      smp_d = (smp_q == SMP_LAST) ? '0 : smp_q + SMP_W'(1);
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    if (at_v0) v0_d = sync2_q;
    if (at_v1) v1_d = sync2_q;

    case (state_q)
      S_IDLE: begin
        bit_d  = '0;
        perr_d = 1'b0;
        ferr_d = 1'b0;
        zero_d = 1'b1;
        if (start_edge) state_d = S_START;
      end
      S_START: begin
        if (at_dec && maj) begin
          state_d = S_IDLE;
        end else if (at_wrap) begin
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (at_dec) begin
          shift_d = {maj, shift_q[DATA_WIDTH-1:1]};
          if (maj) zero_d = 1'b0;
        end
        if (at_wrap) begin
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = HAS_PAR ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (at_dec) begin
          perr_d = ((^shift_q) ^ maj) != PAR_ODD;
          if (maj) zero_d = 1'b0;
        end
        if (at_wrap) begin
          bit_d   = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (at_dec) begin
          ferr_d = stop_ferr;
          zero_d = stop_zero;
          // Last stop decision closes the frame without waiting for the bit end.
          if (bit_q == STOP_LAST) begin
            if (stop_zero) begin
              brk_d   = 1'b1;
              state_d = S_BRKW;
            end else begin
              push_d  = 1'b1;
              word_d  = {stop_ferr, perr_q, shift_q};
              state_d = S_IDLE;
            end
          end
        end else if (at_wrap) begin
          bit_d = bit_q + BIT_W'(1);
        end
      end
      S_BRKW: begin
        if (sync2_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_d == S_IDLE) || (state_d == S_BRKW)) begin
      div_d = '0;
      smp_d = '0;
    end
  end

  // Frame FSM and receive datapath registers.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      smp_q   <= '0;
      bit_q   <= '0;
      v0_q    <= 1'b1;
      v1_q    <= 1'b1;
      shift_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      zero_q  <= 1'b1;
      push_q  <= 1'b0;
      brk_q   <= 1'b0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      smp_q   <= smp_d;
      bit_q   <= bit_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      zero_q  <= zero_d;
      push_q  <= push_d;
      brk_q   <= brk_d;
      word_q  <= word_d;
    end
  end

  // A push into a full FIFO survives only if the head is popped in the same
  // cycle; pop is gated by non-empty so ready on an empty FIFO does nothing.
  assign pop  = (level_q != '0) && rx_if.rx_ready;
  assign full = (level_q == LEVEL_FULL);
  assign wr   = push_q && (!full || pop);

  // FIFO pointer/occupancy next state and overrun detection.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    ovr_d   = push_q && full && !pop;
    if (wr)  wptr_d = wptr_q + PTR_W'(1);
    if (pop) rptr_d = rptr_q + PTR_W'(1);
    if (wr && !pop)      level_d = level_q + LEVEL_W'(1);
    else if (!wr && pop) level_d = level_q - LEVEL_W'(1);
  end

  // FIFO control registers.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovr_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovr_q   <= ovr_d;
    end
  end

  // FIFO storage; cleared on reset so the idle head reads as zero.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (wr) begin
      mem_q[wptr_q] <= word_q;
    end
  end

  assign head                = mem_q[rptr_q];
  assign rx_if.rx_data       = head[DATA_WIDTH-1:0];
  assign rx_if.rx_parity_err = head[DATA_WIDTH];
  assign rx_if.rx_frame_err  = head[DATA_WIDTH+1];
  assign rx_if.rx_valid      = (level_q != '0);
  assign rx_if.rx_level      = level_q;
  assign rx_if.rx_overrun    = ovr_q;
  assign rx_if.rx_break      = brk_q;

endmodule

// File: doc/uart_rx_buffered.md
# uart_rx_buffered

Parametrised UART receiver with 16x-oversampled majority-vote sampling, configurable frame format, break detection and an on-chip receive FIFO with a valid/ready drain port. It sits between the RXD pin and the system-side consumer. It is the buffered, multi-format successor to the single-word receiver: no word is lost while the consumer is busy, up to FIFO_DEPTH words.

## Interface
Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD_RATE, 115200: line rate in baud.
- OVERSAMPLE, 16: sample ticks per bit; must be even and at least 8.
- DATA_WIDTH, 8: data bits per frame, 5..9.
- PARITY, "NONE": one of "NONE", "EVEN", "ODD".
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 8: number of words; must be a power of two and at least 2.

Ports:
- clk in 1: system clock, all logic on rising edge.
- arstn in 1: asynchronous active-low reset.
- RXD in 1: serial line, asynchronous, idles high.
- rx_data out DATA_WIDTH: data field of the FIFO head word.
- rx_parity_err out 1: parity flag of the head word.
- rx_frame_err out 1: stop-bit flag of the head word.
- rx_valid out 1: FIFO not empty.
- rx_ready in 1: consumer accepts the head word.
- rx_level out $clog2(FIFO_DEPTH+1): current FIFO occupancy.
- rx_overrun out 1: one-cycle pulse when a completed word is dropped because the FIFO is full.
- rx_break out 1: one-cycle pulse on each detected break condition.

## Operation
**Input synchroniser and edge detect**
- RXD passes through a 2-flop synchroniser, reset value 1.
- A third flop holds the previous synchronised value.
- A start edge is a synchronised 1→0 transition while the FSM is in IDLE.

**Tick generator**
- TICK_DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer division.
- TICK_DIV < 1 is an elaboration error.
- The divider counts 0..TICK_DIV-1 and emits a one-cycle tick at TICK_DIV-1.
- The divider is held at 0 in IDLE and BREAK_WAIT. It starts counting on the cycle after the start edge.

**Sample counter**
- Counts ticks 0..OVERSAMPLE-1 within each bit, then wraps; the wrap marks the bit boundary.
- The line is sampled at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
- The bit value is the 2-of-3 majority, decided at tick OVERSAMPLE/2+1.

**FSM states**
- IDLE: on a start edge, go to START.
- START: at the decision tick, majority 1 means a false start: return to IDLE with no effect. Otherwise go to DATA at the bit boundary.
- DATA: DATA_WIDTH bits, LSB first, shifted into a shift register. After the last bit's boundary, go to PARITY if PARITY≠"NONE", else to STOP.
- PARITY: check the XOR of the data bits and the parity bit. EVEN requires 0 and ODD requires 1; a mismatch sets parity_err.
- STOP: STOP_BITS bits. Any stop bit sampled 0 sets frame_err.
  - At the decision tick of the last stop bit, the frame completes and the FSM goes straight to IDLE, without waiting for the bit boundary. This allows back-to-back frames with baud mismatch.
- Break: if every data, parity and stop bit sampled 0, do not write the word. Pulse rx_break and enter BREAK_WAIT.
- BREAK_WAIT: stay until the synchronised RXD is 1, then go to IDLE.

**FIFO**
- Each entry is {frame_err, parity_err, data}, written in arrival order. The read side is show-ahead.
- Push: on frame completion, not a break, and not full.
- Pop: rx_valid && rx_ready.
- Push on a full FIFO: if a pop occurs in the same cycle, the push is accepted and rx_level is unchanged. Otherwise the word is dropped and rx_overrun pulses.
- Push and pop together on an empty FIFO: the push is accepted and the pop is ignored, because rx_valid was 0.
- rx_ready while rx_valid=0 has no effect.

**Reset**
- arstn low at any time, including mid-frame, immediately forces:
  - FSM to IDLE, all counters to 0.
  - FIFO empty and storage cleared.
  - rx_valid=0, rx_data=0, rx_parity_err=0, rx_frame_err=0, rx_level=0, rx_overrun=0, rx_break=0.
- A partial frame in progress is discarded.

## Timing
- Bit period = TICK_DIV*OVERSAMPLE clk.
- The start edge is seen 2–3 clk after the RXD fall, because of the synchroniser.
- Push occurs on the clk after the final stop-bit decision tick. rx_valid and rx_level update one clk after the push.
- rx_data and the error flags change only on push-into-empty or pop. They are stable while rx_valid=1 and rx_ready=0.
- Pop is registered: after a pop, the next head word appears on the following clk.
- rx_overrun and rx_break are asserted for exactly one clk each.
- The next start edge is accepted from the clk after the FSM re-enters IDLE.

## Test plan
Bench parameters: CLK_FREQ=3_686_400 and BAUD_RATE=115200, giving TICK_DIV=2 and 32 clk/bit. All other parameters default unless stated.
1. Send 8N1 0xA5 with rx_ready=0 → rx_valid=1, rx_data=0xA5, both error flags 0, rx_level=1. Assert rx_ready for 1 clk → rx_valid=0, rx_level=0.
2. Set PARITY="EVEN" and send 0x03 with parity bit 1 → word stored with rx_data=0x03, rx_parity_err=1, rx_frame_err=0. The same frame with parity bit 0 → rx_parity_err=0.
3. Hold RXD low for 10 clk (glitch) → no push, rx_level stays 0. A following valid frame 0x3C is received correctly.
4. Hold RXD low for 20 bit times → exactly one rx_break pulse and no FIFO entry. After RXD returns high, frame 0x55 yields rx_data=0x55 with no errors.
5. With rx_ready=0, send 9 back-to-back frames 0x00..0x08 → rx_level=8, one rx_overrun pulse at the 9th frame. Draining yields 0x00..0x07 in order.
6. Set STOP_BITS=2 and send 0x81 with the second stop bit 0 → rx_frame_err=1, rx_data=0x81. Pulse arstn low mid-way through the next frame → all outputs return to reset values. The frame after that, 0x7E, is received with no errors.
